// File: rtl/tdm_demux_if.sv
// Bus between a TDM word source and the demultiplexer: the multiplexed input
// lane plus the restored parallel channels and framing status.
interface tdm_demux_if #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
);
  localparam int SW = $clog2(CHANNELS);

  logic [WIDTH-1:0]          din;
  logic                      din_valid;
  logic                      frame_start;
  logic [CHANNELS*WIDTH-1:0] ch_data;
  logic [CHANNELS-1:0]       ch_valid;
  logic [SW-1:0]             slot;
  logic                      frame_done;
  logic                      sync_err;

  // Source side: drives the lane, observes the channels.
  modport master (
    output din, din_valid, frame_start,
    input  ch_data, ch_valid, slot, frame_done, sync_err
  );

  // Demultiplexer side: consumes the lane, drives the channels.
  modport slave (
    input  din, din_valid, frame_start,
    output ch_data, ch_valid, slot, frame_done, sync_err
  );
endinterface

// File: rtl/tdm_demux.sv
// Time-division demultiplexer: steers each valid input word into one of
// CHANNELS held output registers following a wrapping slot counter that
// frame_start realigns to slot 0. A frame_start arriving mid-frame raises a
// sticky sync error but still wins over the counter.
module tdm_demux #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
) (
  input  logic         clk,
  input  logic         rst,
  tdm_demux_if.slave   bus
);
  localparam int            SW   = $clog2(CHANNELS);
  // Explicit wrap point so non-power-of-2 channel counts never reach an
  // unused slot index.
  localparam logic [SW-1:0] LAST = SW'(CHANNELS - 1);

  logic [CHANNELS*WIDTH-1:0] ch_data_q,    ch_data_d;
  logic [CHANNELS-1:0]       ch_valid_q,   ch_valid_d;
  logic [SW-1:0]             slot_q,       slot_d;
  logic                      frame_done_q, frame_done_d;
  logic                      sync_err_q,   sync_err_d;
  logic [SW-1:0]             tgt;

  // Next-state: pick the target slot, write the word, advance the counter.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no path leaves
    // it unassigned; otherwise synthesis infers a latch to hold the old value.
    ch_data_d    = ch_data_q;
    ch_valid_d   = '0;
    slot_d       = slot_q;
    frame_done_d = 1'b0;
    sync_err_d   = sync_err_q;
    tgt          = bus.frame_start ? '0 : slot_q;

    if (bus.din_valid) begin
      ch_data_d[int'(tgt)*WIDTH +: WIDTH] = bus.din;
      ch_valid_d   = CHANNELS'(1) << tgt;
      frame_done_d = (tgt == LAST);
      slot_d       = (tgt == LAST) ? '0 : tgt + 1'b1;
      // Resync mid-frame: flag it, but channel 0 still takes the word.
      if (bus.frame_start && (slot_q != '0)) begin
        sync_err_d = 1'b1;
      end
    end
  end

  // State registers; reset clears channel data too, so a partial frame is lost.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      ch_data_q    <= '0;
      ch_valid_q   <= '0;
      slot_q       <= '0;
      frame_done_q <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      ch_data_q    <= ch_data_d;
      ch_valid_q   <= ch_valid_d;
      slot_q       <= slot_d;
      frame_done_q <= frame_done_d;
      sync_err_q   <= sync_err_d;
    end
  end

  assign bus.ch_data    = ch_data_q;
  assign bus.ch_valid   = ch_valid_q;
  assign bus.slot       = slot_q;
  assign bus.frame_done = frame_done_q;
  assign bus.sync_err   = sync_err_q;
endmodule
